// File: rtl/arm_rf_pkg.sv
// arm_rf_pkg: shared types and helpers for the mode-banked ARM register file.
//   mode_e       - register bank selected by the current processor mode
//   Cpsr*        - 5-bit CPSR mode field encodings
//   NUM_PHYS     - physical register count (30 GPR slots + one PC slot)
//   phys_idx_t   - physical register index
//   decode_mode  - CPSR mode field plus usr_bank override -> mode_e
package arm_rf_pkg;

    localparam int unsigned NUM_PHYS = 31;

    typedef logic [4:0] phys_idx_t;

    typedef enum logic [2:0] {
        ModeUsr,
        ModeFiq,
        ModeIrq,
        ModeSvc,
        ModeAbt,
        ModeUnd
    } mode_e;

    localparam logic [4:0] CpsrUsr = 5'b10000;
    localparam logic [4:0] CpsrFiq = 5'b10001;
    localparam logic [4:0] CpsrIrq = 5'b10010;
    localparam logic [4:0] CpsrSvc = 5'b10011;
    localparam logic [4:0] CpsrAbt = 5'b10111;
    localparam logic [4:0] CpsrUnd = 5'b11011;
    localparam logic [4:0] CpsrSys = 5'b11111;

    // Slot reserved for R15; never written, reads are served from pc_in.
    localparam phys_idx_t PhysPc = 5'd30;

    // SYS and any illegal encoding fall back to the user bank.
    function automatic mode_e decode_mode(input logic [4:0] mode, input logic usr_bank);
        mode_e m;
        m = ModeUsr;
        if (!usr_bank) begin
            case (mode)
                CpsrFiq: m = ModeFiq;
                CpsrIrq: m = ModeIrq;
                CpsrSvc: m = ModeSvc;
                CpsrAbt: m = ModeAbt;
                CpsrUnd: m = ModeUnd;
                default: m = ModeUsr;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/arm_reg_map.sv
// arm_reg_map: combinational logical-to-physical register mapping.
//   addr_i  - logical register number R0..R15
//   mode_i  - decoded bank
//   phys_o  - physical index
// Layout: 0-7 R0-R7 (shared), 8-12 USR R8-R12, 13-14 USR R13-R14,
// 15-19 FIQ R8-R12, 20-21 FIQ R13-R14, 22-23 IRQ, 24-25 SVC, 26-27 ABT,
// 28-29 UND, 30 PC.
module arm_reg_map
    import arm_rf_pkg::*;
(
    input  logic [3:0] addr_i,
    input  mode_e      mode_i,
    output phys_idx_t  phys_o
);

    phys_idx_t sp_lr_base;

    always_comb begin
        case (mode_i)
            ModeFiq: sp_lr_base = 5'd20;
            ModeIrq: sp_lr_base = 5'd22;
            ModeSvc: sp_lr_base = 5'd24;
            ModeAbt: sp_lr_base = 5'd26;
            ModeUnd: sp_lr_base = 5'd28;
            default: sp_lr_base = 5'd13;
        endcase
    end

    always_comb begin
        phys_o = {1'b0, addr_i};
        if (addr_i == 4'd15) begin
            phys_o = PhysPc;
        end else if (addr_i >= 4'd13) begin
            // R13 -> +0, R14 -> +1; bit 1 distinguishes 4'b1101 from 4'b1110.
            phys_o = sp_lr_base + {4'b0000, addr_i[1]};
        end else if (addr_i >= 4'd8) begin
            if (mode_i == ModeFiq) begin
                phys_o = {1'b0, addr_i} + 5'd7;
            end
        end
    end

endmodule

// File: rtl/arm_banked_regfile.sv
// arm_banked_regfile: mode-banked ARM register file with NUM_RD combinational
// read ports, two write ports, optional write-to-read bypass and a per-register
// load-pending scoreboard.
//   clk, rst            - clock, synchronous active-high reset
//   mode, usr_bank      - CPSR mode field and force-USR override for this cycle
//   ra / rd / rd_pending - per-port logical address, data, pending flag
//   we0/wa0/wd0         - write port 0 (ALU result), wins on collision
//   we1/wa1/wd1         - write port 1 (load data / base writeback)
//   ld_issue, ld_addr   - mark load destination pending
//   pc_in               - value returned for R15 reads
module arm_banked_regfile
    import arm_rf_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 3,
    parameter int unsigned BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [4:0]                     mode,
    input  logic                           usr_bank,
    input  logic [NUM_RD-1:0][3:0]         ra,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
    output logic [NUM_RD-1:0]              rd_pending,
    input  logic                           we0,
    input  logic [3:0]                     wa0,
    input  logic [DATA_W-1:0]              wd0,
    input  logic                           we1,
    input  logic [3:0]                     wa1,
    input  logic [DATA_W-1:0]              wd1,
    input  logic                           ld_issue,
    input  logic [3:0]                     ld_addr,
    input  logic [DATA_W-1:0]              pc_in
);

    mode_e mode_sel;
    assign mode_sel = decode_mode(mode, usr_bank);

    // Address mapping
    phys_idx_t rd_phys [NUM_RD];
    phys_idx_t wr0_phys;
    phys_idx_t wr1_phys;
    phys_idx_t ld_phys;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_map
        arm_reg_map u_rd_map (
            .addr_i (ra[i]),
            .mode_i (mode_sel),
            .phys_o (rd_phys[i])
        );
    end

    arm_reg_map u_wr0_map (
        .addr_i (wa0),
        .mode_i (mode_sel),
        .phys_o (wr0_phys)
    );

    arm_reg_map u_wr1_map (
        .addr_i (wa1),
        .mode_i (mode_sel),
        .phys_o (wr1_phys)
    );

    arm_reg_map u_ld_map (
        .addr_i (ld_addr),
        .mode_i (mode_sel),
        .phys_o (ld_phys)
    );

    // Effective enables: R15 writes belong to fetch, and reset drops everything.
    logic wen0;
    logic wen1;
    logic ld_ok;
    assign wen0  = we0 && (wa0 != 4'd15) && !rst;
    assign wen1  = we1 && (wa1 != 4'd15) && !rst;
    assign ld_ok = ld_issue && (ld_addr != 4'd15) && !rst;

    // Storage
    logic [DATA_W-1:0] regs_q [NUM_PHYS];
    logic [DATA_W-1:0] regs_d [NUM_PHYS];

    always_comb begin
        regs_d = regs_q;
        if (rst) begin
            for (int k = 0; k < NUM_PHYS; k++) begin
                regs_d[k] = '0;
            end
        end else begin
            // Port 1 first so port 0 overwrites it on a collision.
            if (wen1) regs_d[wr1_phys] = wd1;
            if (wen0) regs_d[wr0_phys] = wd0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Scoreboard
    logic [NUM_PHYS-1:0] pend_q;
    logic [NUM_PHYS-1:0] pend_d;
    logic [NUM_PHYS-1:0] pend_clr;
    logic [NUM_PHYS-1:0] pend_set;
    logic [NUM_PHYS-1:0] pend_vis;

    always_comb begin
        pend_clr = '0;
        pend_set = '0;
        if (wen0)  pend_clr[wr0_phys] = 1'b1;
        if (wen1)  pend_clr[wr1_phys] = 1'b1;
        if (ld_ok) pend_set[ld_phys]  = 1'b1;
        // Set after clear: a newly issued load stays outstanding.
        pend_d = rst ? '0 : ((pend_q & ~pend_clr) | pend_set);
        pend_vis = (BYPASS != 0) ? (pend_q & ~pend_clr) : pend_q;
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    // Read ports
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd[i]         = regs_q[rd_phys[i]];
            rd_pending[i] = pend_vis[rd_phys[i]];
            if (BYPASS != 0) begin
                if (wen1 && (rd_phys[i] == wr1_phys)) rd[i] = wd1;
                if (wen0 && (rd_phys[i] == wr0_phys)) rd[i] = wd0;
            end
            if (ra[i] == 4'd15) begin
                rd[i]         = pc_in;
                rd_pending[i] = 1'b0;
            end
            if (rst) begin
                rd[i]         = '0;
                rd_pending[i] = 1'b0;
            end
        end
    end

endmodule
